sobel_window_feeder: RTL and testbench

//  Sits between the grayscale converter and sobel_control.
//  - Accepts grayscale pixels in raster order and stores the 3 most recent image rows in line buffers.
//  - For each 3-row band it replays the pixels column by column in the order sobel_control expects:

---
 rtl/sobel_window_feeder_if.sv | 24 ++
 rtl/sobel_window_feeder.sv | 134 +++++++++++++
 tb/tb_sobel_window_feeder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_feeder_if.sv
// Pixel-stream bundle between the grayscale converter, the window feeder and sobel_control.
// The master modport is the upstream/test side; the slave modport is the feeder.
interface sobel_window_feeder_if #(
    parameter int unsigned PIXEL_WIDTH = 8
);
    logic                   sof_i;
    logic                   px_valid_i;
    logic [PIXEL_WIDTH-1:0] px_i;
    logic                   in_rdy_o;
    logic                   start_sobel_o;
    logic                   px_rdy_o;
    logic [PIXEL_WIDTH-1:0] px_o;
    logic                   frame_done_o;

    modport master (
        output sof_i, px_valid_i, px_i,
        input  in_rdy_o, start_sobel_o, px_rdy_o, px_o, frame_done_o
    );

    modport slave (
        input  sof_i, px_valid_i, px_i,
        output in_rdy_o, start_sobel_o, px_rdy_o, px_o, frame_done_o
    );
endinterface

// File: rtl/sobel_window_feeder.sv
// Buffers three image rows and replays each 3-row band column by column (top, mid, bottom)
// for sobel_control; the input is stalled while a band is being replayed.
module sobel_window_feeder #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned IMG_WIDTH   = 16,
    parameter int unsigned IMG_HEIGHT  = 16,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    sobel_window_feeder_if.slave bus
);
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                 state;
    logic [COL_W-1:0]       col_in;
    logic [ROW_W-1:0]       row_in;
    logic [1:0]             wr_bank;
    logic [COL_W-1:0]       col_out;
    logic [1:0]             sub;
    logic [GAP_W-1:0]       gap_cnt;
    logic [2:0]             bank_sum;
    logic [1:0]             rd_bank;
    logic                   accept;
    logic [PIXEL_WIDTH-1:0] line_bank [3][IMG_WIDTH];

    assign bus.in_rdy_o = (state == FILL);
    assign accept       = bus.px_valid_i && bus.in_rdy_o;

    // wr_bank tracks row_in % 3, which is also the top bank of the band being replayed.
    assign bank_sum = {1'b0, wr_bank} + {1'b0, sub};
    assign rd_bank  = (bank_sum >= 3'd3) ? 2'(bank_sum - 3'd3) : bank_sum[1:0];

    // Line storage needs no reset; a pixel arriving with sof_i always lands at row 0 / col 0.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (bus.sof_i) begin
                line_bank[0][0] <= bus.px_i;
            end else begin
                line_bank[wr_bank][col_in] <= bus.px_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state             <= FILL;
            col_in            <= '0;
            row_in            <= '0;
            wr_bank           <= '0;
            col_out           <= '0;
            sub               <= '0;
            gap_cnt           <= '0;
            bus.start_sobel_o <= 1'b0;
            bus.px_rdy_o      <= 1'b0;
            bus.px_o          <= '0;
            bus.frame_done_o  <= 1'b0;
        end else if (bus.sof_i) begin
            state             <= FILL;
            col_in            <= accept ? COL_W'(1) : '0;
            row_in            <= '0;
            wr_bank           <= '0;
            col_out           <= '0;
            sub               <= '0;
            gap_cnt           <= '0;
            bus.start_sobel_o <= 1'b0;
            bus.px_rdy_o      <= 1'b0;
            bus.frame_done_o  <= 1'b0;
        end else begin
            bus.start_sobel_o <= 1'b0;
            bus.px_rdy_o      <= 1'b0;
            bus.frame_done_o  <= 1'b0;
            unique case (state)
                FILL: begin
                    if (accept) begin
                        if (col_in == COL_W'(IMG_WIDTH - 1)) begin
                            col_in  <= '0;
                            row_in  <= row_in + ROW_W'(1);
                            wr_bank <= (wr_bank == 2'd2) ? 2'd0 : wr_bank + 2'd1;
                            if (row_in >= ROW_W'(2)) begin
                                state   <= EMIT;
                                col_out <= '0;
                                sub     <= '0;
                            end
                        end else begin
                            col_in <= col_in + COL_W'(1);
                        end
                    end
                end
                EMIT: begin
                    bus.start_sobel_o <= 1'b1;
                    bus.px_rdy_o      <= 1'b1;
                    bus.px_o          <= line_bank[rd_bank][col_out];
                    if (sub == 2'd2) begin
                        sub <= '0;
                        if (col_out == COL_W'(IMG_WIDTH - 1)) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            col_out <= col_out + COL_W'(1);
                        end
                    end else begin
                        sub <= sub + 2'd1;
                    end
                end
                GAP: begin
                    // First GAP cycle still shows the last pixel, so count one extra to get
                    // GAP_CYCLES visible idle cycles before accepting input again.
                    if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
                        state   <= FILL;
                        gap_cnt <= '0;
                        if (row_in == ROW_W'(IMG_HEIGHT)) begin
                            bus.frame_done_o <= 1'b1;
                            row_in           <= '0;
                            col_in           <= '0;
                            wr_bank          <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_window_feeder.sv
// Randomized bench for sobel_window_feeder: frames are fed with random idle cycles and the
// replayed stream is compared against band sequences built directly from the frame array.
module tb_sobel_window_feeder;
    localparam int unsigned PW   = 8;
    localparam int unsigned W    = 16;
    localparam int unsigned H    = 16;
    localparam int unsigned GAP  = 2;
    localparam int unsigned BAND = 3 * W;

    logic clk_i    = 1'b0;
    logic nreset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    sobel_window_feeder_if #(.PIXEL_WIDTH(PW)) bus ();

    sobel_window_feeder #(
        .PIXEL_WIDTH(PW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i   (clk_i),
        .nreset_i(nreset_i),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int img [H][W];
    int exp_q[$];
    int obs_q[$];
    int run_q[$];
    int gap_q[$];
    int viol   = 0;
    int fd_cnt = 0;
    int cur_run = 0;
    int gcnt = 0;
    bit in_gap = 1'b0;
    logic prev_start = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: collects replayed pixels, band lengths and idle-gap lengths.
    always @(negedge clk_i) begin
        if (bus.px_rdy_o) begin
            obs_q.push_back(int'(bus.px_o));
            cur_run++;
        end else if (cur_run > 0) begin
            run_q.push_back(cur_run);
            cur_run = 0;
        end
        if (bus.start_sobel_o !== bus.px_rdy_o) viol++;
        if (bus.start_sobel_o && bus.in_rdy_o) viol++;
        if (bus.frame_done_o) fd_cnt++;
        if (prev_start && !bus.start_sobel_o) begin
            in_gap = 1'b1;
            gcnt   = 0;
        end
        if (in_gap) begin
            if (bus.in_rdy_o) begin
                gap_q.push_back(gcnt);
                in_gap = 1'b0;
            end else begin
                gcnt++;
            end
        end
        prev_start = bus.start_sobel_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        @(negedge clk_i);
        #1;
        obs_q.delete();
        run_q.delete();
        gap_q.delete();
        cur_run = 0;
        in_gap  = 1'b0;
        viol    = 0;
        fd_cnt  = 0;
    endtask

    task automatic send_px(input int v);
        int budget;
        if ($urandom_range(3) == 0) @(negedge clk_i);
        bus.px_valid_i = 1'b1;
        bus.px_i       = PW'(v);
        budget = 0;
        while (!bus.in_rdy_o && budget < 1000) begin
            @(negedge clk_i);
            budget++;
        end
        if (!bus.in_rdy_o) check("accept_timeout", 0, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        bus.px_valid_i = 1'b0;
    endtask

    task automatic send_rows(input int r0, input int r1, input int c0);
        for (int r = r0; r <= r1; r++) begin
            for (int c = (r == r0) ? c0 : 0; c < W; c++) send_px(img[r][c]);
        end
    endtask

    task automatic build_bands(input int nbands);
        exp_q.delete();
        for (int k = 0; k < nbands; k++)
            for (int c = 0; c < W; c++)
                for (int s = 0; s < 3; s++) exp_q.push_back(img[k + s][c]);
    endtask

    task automatic wait_obs(input int n, input int budget);
        int t = 0;
        while (obs_q.size() < n && t < budget) begin
            @(negedge clk_i);
            t++;
        end
        if (obs_q.size() < n) check("wait_timeout", obs_q.size(), n);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_px"}, obs_q[i], exp_q[i]);
            if (obs_q[i] != exp_q[i]) break;
        end
    endtask

    function automatic int obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return -1;
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 16 * r + c;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
    endtask

    initial begin
        int ramp_head [6];
        ramp_head = '{0, 16, 32, 1, 17, 33};
        bus.sof_i      = 1'b0;
        bus.px_valid_i = 1'b0;
        bus.px_i       = '0;

        // Reset values
        repeat (3) @(negedge clk_i);
        check("rst_in_rdy", int'(bus.in_rdy_o), 1);
        check("rst_start", int'(bus.start_sobel_o), 0);
        check("rst_px_rdy", int'(bus.px_rdy_o), 0);
        check("rst_px", int'(bus.px_o), 0);
        check("rst_frame_done", int'(bus.frame_done_o), 0);
        nreset_i = 1'b1;

        // Two rows only: nothing replayed yet
        fill_ramp();
        clear_mon();
        send_rows(0, 1, 0);
        repeat (5) @(negedge clk_i);
        check("fill_no_px", obs_q.size(), 0);
        check("fill_in_rdy", int'(bus.in_rdy_o), 1);

        // Rest of the ramp frame, input held valid across replay stalls
        send_rows(2, H - 1, 0);
        wait_obs((H - 2) * BAND, 5000);
        repeat (6) @(negedge clk_i);
        build_bands(H - 2);
        compare_stream("ramp_frame");
        for (int i = 0; i < 6; i++) check("ramp_band0_head", obs_at(i), ramp_head[i]);
        check("ramp_band1_top", obs_at(BAND), 16);
        check("ramp_band1_mid", obs_at(BAND + 1), 32);
        check("ramp_band1_bot", obs_at(BAND + 2), 48);
        check("ramp_band13_top", obs_at(13 * BAND), 208);
        check("ramp_band13_mid", obs_at(13 * BAND + 1), 224);
        check("ramp_band13_bot", obs_at(13 * BAND + 2), 240);
        check("ramp_runs", run_q.size(), H - 2);
        foreach (run_q[i]) check("ramp_run_len", run_q[i], BAND);
        check("ramp_gaps", gap_q.size(), H - 2);
        foreach (gap_q[i]) check("ramp_gap_len", gap_q[i], GAP);
        check("ramp_frame_done", fd_cnt, 1);
        check("ramp_protocol", viol, 0);

        // Back-to-back random frame with no sof
        fill_random();
        clear_mon();
        send_rows(0, H - 1, 0);
        wait_obs((H - 2) * BAND, 5000);
        repeat (6) @(negedge clk_i);
        build_bands(H - 2);
        compare_stream("rand_frame");
        check("rand_frame_done", fd_cnt, 1);
        check("rand_protocol", viol, 0);

        // sof in the middle of band 3
        fill_ramp();
        clear_mon();
        send_rows(0, 5, 0);
        repeat (10) @(negedge clk_i);
        check("sof_mid_band_active", int'(bus.px_rdy_o), 1);
        check("sof_band3_started", int'(obs_q.size() > 3 * BAND), 1);
        bus.sof_i = 1'b1;
        @(negedge clk_i);
        bus.sof_i = 1'b0;
        check("sof_px_rdy_drop", int'(bus.px_rdy_o), 0);
        check("sof_start_drop", int'(bus.start_sobel_o), 0);
        check("sof_in_rdy", int'(bus.in_rdy_o), 1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'hAA;
        clear_mon();
        send_rows(0, 2, 0);
        wait_obs(BAND, 500);
        repeat (4) @(negedge clk_i);
        build_bands(1);
        compare_stream("sof_aa");

        // sof together with the first pixel of a new frame
        fill_random();
        clear_mon();
        bus.sof_i      = 1'b1;
        bus.px_valid_i = 1'b1;
        bus.px_i       = PW'(img[0][0]);
        @(posedge clk_i);
        @(negedge clk_i);
        bus.sof_i      = 1'b0;
        bus.px_valid_i = 1'b0;
        send_rows(0, 2, 1);
        wait_obs(BAND, 500);
        repeat (4) @(negedge clk_i);
        build_bands(1);
        compare_stream("sof_px");

        // Async reset in the middle of band 1
        send_rows(3, 3, 0);
        repeat (7) @(negedge clk_i);
        check("arst_mid_band_active", int'(bus.px_rdy_o), 1);
        #2;
        nreset_i = 1'b0;
        #1;
        check("arst_px_rdy", int'(bus.px_rdy_o), 0);
        check("arst_start", int'(bus.start_sobel_o), 0);
        check("arst_px", int'(bus.px_o), 0);
        check("arst_in_rdy", int'(bus.in_rdy_o), 1);
        @(negedge clk_i);
        nreset_i = 1'b1;
        fill_random();
        clear_mon();
        send_rows(0, 2, 0);
        wait_obs(BAND, 500);
        repeat (4) @(negedge clk_i);
        build_bands(1);
        compare_stream("post_reset");
        check("post_reset_protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
